// File: rtl/jtag_probe_pkg.sv
// Shared types and field-position helpers for the JTAG probe bridge.
// Holds the command opcode and readout mode enums.
// Also holds the helpers that locate fields inside the command DR.
package jtag_probe_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_BURST = 2'b01,
    OP_SWI   = 2'b10,
    OP_CLR   = 2'b11
  } op_e;

  typedef enum logic {
    M_READ  = 1'b0,
    M_BURST = 1'b1
  } mode_e;

  // Byte-index field width: at least one bit even for single-byte channels.
  function automatic int by_bits_of(input int chan_w);
    return (chan_w / 8 > 1) ? $clog2(chan_w / 8) : 1;
  endfunction

  // The channel field sits directly above the byte field.
  function automatic int ch_lsb(input int by_bits);
    return by_bits;
  endfunction

  // Smallest DR that holds opcode + channel + byte fields.
  function automatic int min_dr_w(input int ch_bits, input int by_bits);
    return 2 + ch_bits + by_bits;
  endfunction

endpackage

// File: rtl/jtag_dr_shifter.sv
// Command DR shift register, 3-bit bit counter and bypass flop, all on TCK.
// Shift is LSB first. An update clears the bit counter and takes priority over shift.
// byte_done flags the shift edge on which bit_cnt wraps 7->0.
module jtag_dr_shifter #(
  parameter int DR_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tdi,
  input  logic            ir_sel,
  input  logic            sdr,
  input  logic            udr,
  output logic [DR_W-1:0] dr,
  output logic [2:0]      bit_cnt,
  output logic            bypass,
  output logic            byte_done
);

  logic shift_en;
  logic update;

  assign shift_en  = ir_sel & sdr & ~udr;
  assign update    = ir_sel & udr;
  assign byte_done = shift_en & (bit_cnt == 3'd7);

  // Shift the command in, count bits within the current byte, and track bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr      <= '0;
      bit_cnt <= 3'd0;
      bypass  <= 1'b0;
    end else begin
      bypass <= tdi;
      if (update) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        dr      <= {tdi, dr[DR_W-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/jtag_probe_bridge.sv
// Virtual-JTAG bridge: decodes DR commands into channel snapshots, byte readout and switches.
// tdo is combinational from registers. A snapshot becomes visible on the edge after update-DR.
// Out-of-range channel, byte or switch indices set the sticky cmd_err flag.
module jtag_probe_bridge
  import jtag_probe_pkg::*;
#(
  parameter int NCHAN  = 32,
  parameter int CHAN_W = 64,
  parameter int NSWI   = 8,
  parameter int DR_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tdi,
  input  logic                    ir_sel,
  input  logic                    sdr,
  input  logic                    udr,
  input  logic [NCHAN*CHAN_W-1:0] probe,
  output logic                    tdo,
  output logic [NSWI-1:0]         swi,
  output logic                    cmd_err
);

  localparam int CH_BITS  = $clog2(NCHAN);
  localparam int NBYTE    = CHAN_W / 8;
  localparam int BY_BITS  = by_bits_of(CHAN_W);
  localparam int SWI_BITS = $clog2(NSWI);
  localparam int CH_LSB   = ch_lsb(BY_BITS);

  logic [DR_W-1:0]     dr;
  logic [2:0]          bit_cnt;
  logic                bypass;
  logic                byte_done;

  logic [CHAN_W-1:0]   snap;
  logic [BY_BITS-1:0]  byte_idx;
  mode_e               mode;

  op_e                 op;
  logic [CH_BITS-1:0]  ch;
  logic [BY_BITS-1:0]  by;
  logic [SWI_BITS-1:0] swi_idx;
  logic                ch_ok;
  logic                by_ok;
  logic                swi_ok;
  logic                update;
  logic [CHAN_W-1:0]   chan_sel;
  logic                unused_dr_bits;

  jtag_dr_shifter #(.DR_W(DR_W)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .tdi       (tdi),
    .ir_sel    (ir_sel),
    .sdr       (sdr),
    .udr       (udr),
    .dr        (dr),
    .bit_cnt   (bit_cnt),
    .bypass    (bypass),
    .byte_done (byte_done)
  );

  assign update  = ir_sel & udr;
  assign op      = op_e'(dr[DR_W-1 -: 2]);
  assign ch      = dr[CH_LSB +: CH_BITS];
  assign by      = dr[0 +: BY_BITS];
  assign swi_idx = dr[1 +: SWI_BITS];
  assign ch_ok   = 32'(ch) < NCHAN;
  assign by_ok   = 32'(by) < NBYTE;
  assign swi_ok  = 32'(swi_idx) < NSWI;

  // Bits between the fields carry no meaning.
  assign unused_dr_bits = ^dr;

  // Select the addressed channel; an out-of-range index yields an all-zero snapshot.
  always_comb begin
    chan_sel = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (ch == CH_BITS'(k)) chan_sel = probe[k*CHAN_W +: CHAN_W];
    end
  end

  // Decode on update-DR; in burst mode step byte_idx on each completed byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap     <= '0;
      byte_idx <= '0;
      swi      <= '0;
      cmd_err  <= 1'b0;
      mode     <= M_READ;
    end else if (update) begin
      case (op)
        OP_READ, OP_BURST: begin
          mode     <= (op == OP_BURST) ? M_BURST : M_READ;
          snap     <= chan_sel;
          byte_idx <= by_ok ? by : '0;
          if (!ch_ok || !by_ok) cmd_err <= 1'b1;
        end
        OP_SWI: begin
          if (swi_ok) swi[swi_idx] <= dr[0];
          else        cmd_err      <= 1'b1;
        end
        default: begin
          swi     <= '0;
          cmd_err <= 1'b0;
        end
      endcase
    end else if (byte_done && mode == M_BURST) begin
      byte_idx <= (byte_idx == BY_BITS'(NBYTE - 1)) ? '0 : byte_idx + 1'b1;
    end
  end

  assign tdo = ir_sel ? snap[{byte_idx, bit_cnt}] : bypass;

endmodule
